// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller and its clock-gate
// enable register.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAKE = 2'd1,
      EXEC = 2'd2,
      HOLD = 2'd3
   } state_e;

   localparam logic UNIT_AU  = 1'b1;
   localparam logic UNIT_LU  = 1'b0;
   localparam int   REQ_OP_W = 4;

   // Sub-op field sits in the low bits of the request opcode
   localparam int   SUBOP_W   = 3;
   localparam int   SUBOP_LSB = 0;

endpackage

// File: rtl/alu_gate_en_reg.sv
// Falling-edge register pair that presents enable and unit select to the
// AND-style clock gate, so both settle during the low phase of clk.
module alu_gate_en_reg (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_d_i,
   input  logic opc_d_i,
   output logic en_o,
   output logic opc_o
);

   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_o  <= 1'b0;
         opc_o <= 1'b0;
      end else begin
         en_o  <= en_d_i;
         opc_o <= opc_d_i;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 64-bit ALU: captures requests, sequences fixed
// per-unit latencies and drives glitch-free enable/unit select to the clock gate.
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int OP_W     = REQ_OP_W,
   parameter int AU_LAT   = 3,
   parameter int LU_LAT   = 1,
   parameter int HOLD_CYC = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [OP_W-1:0]    req_op,
   input  logic [DATA_W-1:0]  req_a,
   input  logic [DATA_W-1:0]  req_b,
   output logic               enable,
   output logic               opcode,
   output logic [SUBOP_W-1:0] op_q,
   output logic [DATA_W-1:0]  opa_q,
   output logic [DATA_W-1:0]  opb_q,
   output logic               done,
   output logic               busy,
   output state_e             dbg_state_o
);

   localparam int MAX_CNT = (AU_LAT > LU_LAT) ?
                            ((AU_LAT > HOLD_CYC) ? AU_LAT : HOLD_CYC) :
                            ((LU_LAT > HOLD_CYC) ? LU_LAT : HOLD_CYC);
   localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  unit_q, unit_d;
   logic [SUBOP_W-1:0]    op_d;
   logic [DATA_W-1:0]     opa_d, opb_d;
   logic                  accept;
   logic                  req_unit;
   logic                  en_nxt;

   function automatic logic [CNT_W-1:0] lat_m1(input logic unit);
      return (unit == UNIT_AU) ? CNT_W'(AU_LAT - 1) : CNT_W'(LU_LAT - 1);
   endfunction

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; an unaccepted requester keeps op and operands stable.
   assign req_ready   = (state_q == IDLE) || (state_q == HOLD);
   assign busy        = (state_q == WAKE) || (state_q == EXEC);
   assign done        = (state_q == EXEC) && (cnt_q == '0);
   assign accept      = req_valid && req_ready;
   assign req_unit    = req_op[OP_W-1];
   assign dbg_state_o = state_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unit_d  = unit_q;
      op_d    = op_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      case (state_q)
         IDLE: if (accept) state_d = WAKE;
         WAKE: begin
            state_d = EXEC;
            cnt_d   = lat_m1(unit_q);
         end
         EXEC: begin
            if (cnt_q == '0) begin
               if (HOLD_CYC == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = HOLD;
                  cnt_d   = CNT_W'(HOLD_CYC - 1);
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            // A same-unit op skips WAKE because the gated clock is still running
            if (accept) begin
               if (req_unit == unit_q) begin
                  state_d = EXEC;
                  cnt_d   = lat_m1(req_unit);
               end else begin
                  state_d = WAKE;
               end
            end else if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         unit_d = req_unit;
         op_d   = req_op[SUBOP_LSB +: SUBOP_W];
         opa_d  = req_a;
         opb_d  = req_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         unit_q  <= UNIT_LU;
         op_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         unit_q  <= unit_d;
         op_q    <= op_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
      end
   end

   // Both gate inputs are decoded from posedge flops only, then retimed to the falling edge
   assign en_nxt = (state_q != IDLE);

   alu_gate_en_reg u_gate_en (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .en_d_i  (en_nxt),
      .opc_d_i (unit_q),
      .en_o    (enable),
      .opc_o   (opcode)
   );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a timeline model of each op (start, done,
// hold window) checked every cycle, plus hand-computed latency expectations.
module tb_alu_issue_ctrl;
   import alu_ctrl_pkg::*;

   localparam int DATA_W   = 64;
   localparam int OP_W     = 4;
   localparam int AU_LAT   = 3;
   localparam int LU_LAT   = 1;
   localparam int HOLD_CYC = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic [OP_W-1:0]   req_op;
   logic [DATA_W-1:0] req_a, req_b;
   logic              enable, opcode, done, busy;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] opa_q, opb_q;
   state_e            dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   // Model: timeline of the most recent op
   bit                m_has;
   int                m_start, m_done;
   logic              m_unit;
   logic [2:0]        m_sub;
   logic [DATA_W-1:0] m_a, m_b;
   logic              m_en_shown, m_opc_shown;
   logic [31:0]       exp_q[$];

   alu_issue_ctrl #(
      .DATA_W(DATA_W), .OP_W(OP_W), .AU_LAT(AU_LAT), .LU_LAT(LU_LAT), .HOLD_CYC(HOLD_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .enable(enable), .opcode(opcode),
      .op_q(op_q), .opa_q(opa_q), .opb_q(opb_q), .done(done), .busy(busy),
      .dbg_state_o(dbg_state)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int m_lat(input logic u);
      return u ? AU_LAT : LU_LAT;
   endfunction

   function automatic bit m_busy(input int c);
      return m_has && (c >= m_start) && (c <= m_done);
   endfunction

   function automatic bit m_hold(input int c);
      return m_has && (c > m_done) && (c <= m_done + HOLD_CYC);
   endfunction

   task automatic m_reset();
      m_has = 1'b0; m_start = 0; m_done = 0;
      m_unit = 1'b0; m_sub = '0; m_a = '0; m_b = '0;
      m_en_shown = 1'b0; m_opc_shown = 1'b0;
      exp_q.delete();
   endtask

   // Model update: an accept at the end of cycle cyc schedules the op
   always @(posedge clk) begin
      if (rst_n && req_valid && !m_busy(cyc)) begin
         if (m_hold(cyc) && (req_op[OP_W-1] == m_unit))
            m_done = cyc + m_lat(req_op[OP_W-1]);
         else
            m_done = cyc + 1 + m_lat(req_op[OP_W-1]);
         m_start = cyc + 1;
         m_has   = 1'b1;
         m_unit  = req_op[OP_W-1];
         m_sub   = req_op[2:0];
         m_a     = req_a;
         m_b     = req_b;
         exp_q.push_back(32'(m_done));
      end
      cyc++;
   end

   // Compare process: posedge phase and falling-edge phase of every cycle
   always begin
      logic [31:0] exp_d;
      @(posedge clk);
      #1;
      if (chk_en) begin
         chk("busy", busy, m_busy(cyc));
         chk("done", done, m_has && (cyc == m_done));
         chk("req_ready", req_ready, !m_busy(cyc));
         chk("op_q", op_q, m_sub);
         chk("opa_q", opa_q, m_a);
         chk("opb_q", opb_q, m_b);
         chk("enable_stable_at_rise", enable, m_en_shown);
         chk("opcode_stable_at_rise", opcode, m_opc_shown);
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("done_unexpected", done, 1'b0);
            end else begin
               exp_d = exp_q.pop_front();
               chk("done_cycle", cyc, exp_d);
            end
         end
      end
      @(negedge clk);
      m_en_shown = m_busy(cyc) || m_hold(cyc);
      if (m_en_shown) m_opc_shown = m_unit;
      #1;
      if (chk_en) begin
         chk("enable_at_fall", enable, m_en_shown);
         chk("opcode_at_fall", opcode, m_opc_shown);
      end
   end

   // Driver tasks
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, output int t);
      t = -1;
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (req_ready) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) chk("issue_accept_timeout", req_ready, 1'b1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = OP_W'($urandom_range(15, 0));
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
   endtask

   task automatic wait_done(output int d);
      d = -1;
      for (int n = 0; n < 40; n++) begin
         if (done) begin
            d = cyc;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (d < 0) chk("wait_done_timeout", done, 1'b1);
   endtask

   initial begin
      int t1, t2, d1, d2;
      rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_enable", enable, 1'b0);
      chk("rst_opcode", opcode, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_op_q", op_q, 3'b000);
      chk("rst_opa_q", opa_q, 64'd0);
      chk("rst_opb_q", opb_q, 64'd0);
      chk("rst_state", dbg_state, IDLE);
      rst_n = 1'b1;
      #1;
      chk("rst_release_ready", req_ready, 1'b1);
      chk_en = 1'b1;
      idle(2);

      // AU op from IDLE: WAKE, then 3 execute cycles
      issue(4'b1010, 64'h1111_2222_3333_4444, 64'h0123_4567_89ab_cdef, t1);
      wait_done(d1);
      chk("t2_au_latency", d1 - t1, 4);
      chk("t2_subop", op_q, 3'b010);
      chk("t2_enable", enable, 1'b1);
      chk("t2_opcode", opcode, 1'b1);

      // No request after done: enable held two cycles then drops
      repeat (3) @(negedge clk);
      #1;
      chk("t5_enable_last_hold", enable, 1'b1);
      @(negedge clk);
      #1;
      chk("t5_enable_dropped", enable, 1'b0);
      chk("t5_ready", req_ready, 1'b1);
      @(posedge clk);
      #1;

      // LU then LU accepted one cycle after done: no WAKE
      issue(4'b0101, 64'hdead_beef_0000_0001, 64'h5a5a_5a5a_a5a5_a5a5, t1);
      wait_done(d1);
      chk("t3_lu_latency", d1 - t1, 2);
      @(posedge clk);
      #1;
      issue(4'b0011, 64'hffff_ffff_ffff_fffe, 64'h8000_0000_0000_0000, t2);
      chk("t3_accept_in_hold", t2 - d1, 1);
      wait_done(d2);
      chk("t3_hold_latency", d2 - t2, 1);
      chk("t3_enable_kept", enable, 1'b1);

      // Unit switches from HOLD go through WAKE
      issue(4'b1111, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0009, t1);
      wait_done(d1);
      chk("t4_au_after_lu", d1 - t1, 4);
      issue(4'b0110, 64'h0f0f_0f0f_0f0f_0f0f, 64'hf0f0_f0f0_f0f0_f0f0, t2);
      chk("t4_opcode_before_switch", opcode, 1'b1);
      @(negedge clk);
      #1;
      chk("t4_opcode_switched", opcode, 1'b0);
      chk("t4_enable_held", enable, 1'b1);
      wait_done(d2);
      chk("t4_lu_after_au", d2 - t2, 2);

      // Accept in the last HOLD cycle wins over expiry
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      issue(4'b0001, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, t1);
      chk("hx_accept_last_hold", t1 - d2, 2);
      wait_done(d1);
      chk("hx_latency", d1 - t1, 1);

      // Request held through WAKE/EXEC is taken in the first HOLD cycle
      idle(4);
      issue(4'b1000, 64'haaaa_aaaa_aaaa_aaaa, 64'h5555_5555_5555_5555, t1);
      issue(4'b1100, 64'h0000_0000_dead_0001, 64'h0000_0000_beef_0002, t2);
      chk("t6_accept_first_hold", t2 - t1, 5);
      chk("t6_opa_second", opa_q, 64'h0000_0000_dead_0001);
      wait_done(d2);
      chk("t6_same_unit_latency", d2 - t2, 3);

      // Reset in the middle of an AU op
      idle(4);
      issue(4'b1001, 64'h0000_0000_0000_00aa, 64'h0000_0000_0000_00bb, t1);
      @(posedge clk);
      #2;
      chk("t1_busy_before_reset", busy, 1'b1);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      m_reset();
      #1;
      chk("t1_enable_async", enable, 1'b0);
      chk("t1_opcode_async", opcode, 1'b0);
      chk("t1_done_async", done, 1'b0);
      chk("t1_busy_async", busy, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("t1_ready_after_release", req_ready, 1'b1);
      chk_en = 1'b1;
      idle(8);

      idle(3);
      chk("scoreboard_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
